layer_activation_buffer: RTL
============================

// Module: layer_activation_buffer
// PURPOSE
//  Datapath-side responder to the master control path's output strobes. It
//  captures each neuron result on output_wr_en into a ping-pong activation
//  bank. On layer_adv it swaps banks, so that layer's results become the next
//  layer's inputs. Inputs are replayed one per output_shft_en, and the selected
//  activation (external input or stored) goes to the weight/CORDIC MAC.
// PARAMETERS
//  DATA_W   16  signed activation width (two's complement)
//  DEPTH    32  max neurons per layer (entries per bank); power of two
//  AW       5   pointer width, = log2(DEPTH)
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        async active-low reset
//  start          in   1        sync clear of pointers/flags (same pulse as controller start)
//  ext_data       in   DATA_W   network input sample, used while output_sel=0
//  output_sel     in   1        0: act_out from ext_data; 1: act_out from read bank
//  output_wr_en   in   1        write wr_data into write bank at wr_ptr
//  wr_data        in   DATA_W   neuron result (post-activation) from datapath
//  output_shft_en in   1        advance read pointer to next stored activation
//  layer_adv      in   1        layer finished (controller n increment): swap banks
//  act_out        out  DATA_W   registered activation to MAC
//  act_valid      out  1        act_out holds a defined value
//  rd_len         out  AW+1     entries valid in read bank
//  wr_cnt         out  AW+1     entries written in current write bank
//  ovf            out  1        sticky: write attempted with write bank full
//  udf            out  1        sticky: shift attempted with rd_len==0
// BEHAVIOUR
//  Reset (rst_n=0, async): act_out=0, act_valid=0, rd_len=0, wr_cnt=0,
//   ovf=0, udf=0, wr_bank=0, rd_ptr=0. Bank RAM contents are not reset.
//  start=1 (sync, highest priority): same values as reset; RAM untouched;
//   all other inputs ignored that cycle.
//  Write: output_wr_en & wr_cnt<DEPTH -> bank[wr_bank][wr_cnt]<=wr_data,
//   wr_cnt++. If wr_cnt==DEPTH, data dropped, ovf<=1, wr_cnt holds.
//  Read path: rd_bank = ~wr_bank. Each cycle,
//   act_out <= output_sel ? bank[rd_bank][rd_ptr] : ext_data  (1-cycle latency).
//   act_valid <= ~output_sel | (rd_len!=0).
//  Shift: output_shft_en -> rd_ptr <= (rd_ptr==rd_len-1) ? 0 : rd_ptr+1.
//   The wrap to 0 lets each neuron of the next layer replay the full input vector.
//   If rd_len==0: rd_ptr stays 0, udf<=1.
//  Layer advance (layer_adv=1): wr_bank<=~wr_bank; rd_len<=wr_cnt (incl. a same-
//   cycle write); wr_cnt<=0; rd_ptr<=0.
//  Simultaneous events, resolved in priority order:
//   - start over everything.
//   - layer_adv+output_wr_en: the write lands in the old write bank first, then
//     the banks swap.
//   - layer_adv+output_shft_en: the shift is discarded; rd_ptr=0.
//  Only rd_ptr/wr_cnt/wr_bank/rd_len/flags form state; no FSM beyond the bank toggle.
//  Write and read never address the same bank, so no RAM read/write hazard.
// CONFIGURATION
//  LAYER_BUF_RELU_EN defined: on write, a negative wr_data (MSB=1) is stored
//   as 0 (ReLU clamp in the buffer); otherwise stored unchanged.
//  Not defined: wr_data is stored verbatim, including negatives.
// TESTING
//  1 rst_n low mid-write (wr_cnt=3) -> all outputs 0 immediately, async; wr_cnt=0.
//  2 output_sel=0, ext_data=16'h0123 -> act_out=16'h0123 next cycle, act_valid=1.
//  3 write 3 values (5,6,7) then layer_adv, output_sel=1, shift x4
//    -> act_out sequence 5,6,7,5; rd_len=3.
//  4 write DEPTH+1 values -> wr_cnt=DEPTH, ovf=1, entry DEPTH-1 intact.
//  5 layer_adv with output_wr_en (wr_data=9), wr_cnt=2 -> rd_len=3, entry2=9, wr_cnt=0.
//  6 LAYER_BUF_RELU_EN: write 16'hFFF0 then 16'h0004 -> stored 0, 4; undef: FFF0, 0004.

Source files
------------

// File: rtl/layer_activation_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : layer_activation_buffer                                      |
// | Description : Ping-pong activation bank between neural-network layers.     |
// |               Neuron results are captured into the write bank. On a layer  |
// |               advance the banks swap, so that layer's results are replayed |
// |               one per shift to the MAC as the next layer's inputs.         |
// | Options     : LAYER_BUF_RELU_EN - clamp negative results to 0 on write.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module layer_activation_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] ext_data,
  input  logic              output_sel,
  input  logic              output_wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              output_shft_en,
  input  logic              layer_adv,
  output logic [DATA_W-1:0] act_out,
  output logic              act_valid,
  output logic [AW:0]       rd_len,
  output logic [AW:0]       wr_cnt,
  output logic              ovf,
  output logic              udf
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  // Both banks share one array; the bank select is the address MSB.
  logic [DATA_W-1:0] mem [0:2*DEPTH-1];

  logic              wr_bank;
  logic [AW-1:0]     rd_ptr;
  logic              write_ok;
  logic [AW:0]       write_inc;
  logic [AW:0]       rd_last;
  logic [AW:0]       wr_addr;
  logic [AW:0]       rd_addr;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] rd_word;

  // Write is accepted only while the write bank has room; start blocks it.
  assign write_ok  = output_wr_en && (wr_cnt < DEPTH_CNT) && !start;
  assign write_inc = {{AW{1'b0}}, write_ok};
  assign rd_last   = rd_len - {{AW{1'b0}}, 1'b1};
  assign wr_addr   = {wr_bank, wr_cnt[AW-1:0]};
  assign rd_addr   = {~wr_bank, rd_ptr};
  assign rd_word   = mem[rd_addr];

`ifdef LAYER_BUF_RELU_EN
  assign store_data = wr_data[DATA_W-1] ? '0 : wr_data;
`else
  assign store_data = wr_data;
`endif

  // Bank RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem[wr_addr] <= store_data;
    end
  end

  // Pointers, counters, flags and the registered activation output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_out   <= '0;
      act_valid <= 1'b0;
      rd_len    <= '0;
      wr_cnt    <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      wr_bank   <= 1'b0;
      rd_ptr    <= '0;
    end else if (start) begin
      act_out   <= '0;
      act_valid <= 1'b0;
      rd_len    <= '0;
      wr_cnt    <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      wr_bank   <= 1'b0;
      rd_ptr    <= '0;
    end else begin
      act_out   <= output_sel ? rd_word : ext_data;
      act_valid <= ~output_sel | (rd_len != '0);

      if (output_wr_en && (wr_cnt == DEPTH_CNT)) begin
        ovf <= 1'b1;
      end

      if (layer_adv) begin
        // A same-cycle write lands in the old bank and is counted before the swap;
        // any same-cycle shift is dropped so the new layer starts at entry 0.
        wr_bank <= ~wr_bank;
        rd_len  <= wr_cnt + write_inc;
        wr_cnt  <= '0;
        rd_ptr  <= '0;
      end else begin
        wr_cnt <= wr_cnt + write_inc;
        if (output_shft_en) begin
          if (rd_len == '0) begin
            udf    <= 1'b1;
            rd_ptr <= '0;
          end else if ({1'b0, rd_ptr} == rd_last) begin
            // Wrap so every neuron of the next layer sees the full input vector.
            rd_ptr <= '0;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
